multicycle_adder: RTL and testbench
===================================

Name: multicycle_adder

Overview:
- Parametrised successor to the team's one-bit half adder: a WIDTH-bit adder that computes A + B + cin over several clock cycles, CHUNK bits per cycle, with a registered carry between cycles.
- Used where a full-width single-cycle carry chain would not close timing, or where area matters more than throughput.
- Valid/ready handshakes on both the operand side and the result side.

Parameters:
- WIDTH, 32, operand and sum width; must be an integer multiple of CHUNK (elaboration-time assertion).
- CHUNK, 8, bits added per cycle; 1 <= CHUNK <= WIDTH. NUM_CHUNKS = WIDTH/CHUNK.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  (A + B + cin) mod 2^WIDTH.
- out_cout  out  1  carry-out of the MSB.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state = IDLE, in_ready = 1, out_valid = 0, out_sum = 0, out_cout = 0, chunk index = 0, carry register = 0.
- States:
  - IDLE: in_ready = 1. On in_valid: latch in_a, in_b and in_cin into internal registers, clear the chunk index, and go to RUN.
  - RUN: in_ready = 0. Each cycle, add chunk[idx] of A and B plus the carry register. The result goes into out_sum bits [idx*CHUNK +: CHUNK], and the chunk carry-out goes into the carry register. Increment idx. When idx == NUM_CHUNKS-1, also load out_cout with the chunk carry-out and go to DONE.
  - DONE: out_valid = 1; out_sum and out_cout are held stable. On out_ready, out_valid drops next cycle and the state returns to IDLE.
- Latency: accept cycle + NUM_CHUNKS RUN cycles. out_valid rises NUM_CHUNKS+1 edges after the accepting edge. With CHUNK == WIDTH, RUN lasts one cycle.
- Throughput: one operation per NUM_CHUNKS+2 cycles minimum (accept, RUN, DONE handshake). No overlap.
- in_ready is a pure function of state, with no combinational path from out_ready. Operands changing while in RUN/DONE are ignored.
- out_sum bits not yet written in RUN hold stale values. Consumers sample only when out_valid = 1.
- Boundaries:
  - All-ones + 1 gives sum 0, cout 1.
  - A carry rippling across every chunk boundary must propagate correctly via the carry register.
  - With out_ready held high in DONE, out_valid is high for exactly one cycle.
  - With out_ready low, DONE is held indefinitely with no corruption.
  - rst_n asserted mid-RUN or in DONE returns immediately to the reset values. The partial result is discarded.

Optional Feature:
- Macro MULTICYCLE_ADDER_SUB_EN.
- Defined:
  - Extra input port in_sub (1 bit), latched at accept.
  - When in_sub = 1, compute A - B as A + ~B + 1. The latched B is inverted, and the initial carry is forced to 1 with in_cin ignored.
  - out_cout then means "no borrow" (1 when A >= B, unsigned).
- Not defined: the port is absent and the block is add-only.

Decomposition:
- Package multicycle_adder_pkg:
  - state enum (IDLE, RUN, DONE) as a 2-bit typedef;
  - the localparam function for NUM_CHUNKS;
  - the index width $clog2(NUM_CHUNKS), minimum 1.
- Sub-module chunk_adder: combinational, parametrised CHUNK-bit ripple adder (a, b, cin -> sum, cout), instantiated once in the datapath.

Test Plan (WIDTH=16, CHUNK=4 unless stated):
- Basic add: A=0x1234, B=0x0001, cin=0 -> out_sum=0x1235, cout=0; out_valid 5 cycles after accept.
- Full ripple: A=0xFFFF, B=0x0001, cin=0 -> sum=0x0000, cout=1. A=0xFFFF, B=0x0000, cin=1 -> same.
- Backpressure: result 0x00FF+0x0F01 = 0x1000 held with out_ready=0 for 10 cycles -> out_sum stable, in_ready=0 throughout. Then out_ready=1 -> out_valid low next cycle, in_ready=1.
- Reset mid-RUN: assert rst_n=0 after 2 RUN cycles -> out_valid=0, sum=0, in_ready=1 immediately. A new op 0x0003+0x0004 -> 0x0007.
- Back-to-back with out_ready=1: 0x8000+0x8000 (sum 0, cout 1), then 0x7FFF+0x0001 (0x8000, cout 0) -> both correct, each out_valid one cycle wide.
- With MULTICYCLE_ADDER_SUB_EN, in_sub=1: 0x0005-0x0007 -> sum=0xFFFE, cout=0; 0x0007-0x0005 -> 0x0002, cout=1.
- Repeat the 0x1234+0x0001 case with CHUNK=16 (latency 2) and CHUNK=1 (latency 17).

Source files
------------

// File: rtl/multicycle_adder_pkg.sv
// Shared types and sizing helpers for the multi-cycle chunked adder.
package multicycle_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single chunk still needs a one-bit index register.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder; one slice of the multi-cycle datapath.
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic c;

    always_comb begin
        sum = '0;
        c   = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/multicycle_adder.sv
// WIDTH-bit adder evaluated CHUNK bits per cycle with a registered inter-chunk carry.
// Optional subtract mode (A + ~B + 1) is enabled by defining MULTICYCLE_ADDER_SUB_EN.
module multicycle_adder
    import multicycle_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef MULTICYCLE_ADDER_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int NUM_CHUNKS = num_chunks(WIDTH, CHUNK);
    localparam int IDX_W      = idx_width(NUM_CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
            $error("multicycle_adder: WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH");
        end
    endgenerate

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             accept;
    logic             first_carry;
    logic [WIDTH-1:0] b_in;
    int               base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic             c_chunk;

    assign accept = (state == IDLE) && in_valid;

`ifdef MULTICYCLE_ADDER_SUB_EN
    // Subtraction reuses the adder: invert B and force the initial carry.
    assign b_in        = in_sub ? ~in_b : in_b;
    assign first_carry = in_sub ? 1'b1 : in_cin;
`else
    assign b_in        = in_b;
    assign first_carry = in_cin;
`endif

    // Operand capture: held untouched through RUN and DONE.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= in_a;
            b_q <= b_in;
        end
    end

    assign base    = int'(idx) * CHUNK;
    assign a_chunk = a_q[base +: CHUNK];
    assign b_chunk = b_q[base +: CHUNK];

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry),
        .sum  (s_chunk),
        .cout (c_chunk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        idx   <= '0;
                        carry <= first_carry;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_q[base +: CHUNK] <= s_chunk;
                    carry                <= c_chunk;
                    if (idx == LAST_IDX) begin
                        cout_q <= c_chunk;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Scoreboard bench for multicycle_adder: WIDTH=16 with CHUNK=4, 16 and 1 instances side by side.
module tb_multicycle_adder;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef MULTICYCLE_ADDER_SUB_EN
    logic         sub;
`endif
    logic         in_valid_v [3];
    logic         in_ready_v [3];
    logic         out_valid_v[3];
    logic         out_ready_v[3];
    logic [W-1:0] out_sum_v  [3];
    logic         out_cout_v [3];

    int   lat_exp[3] = '{5, 2, 17};
    exp_t sb[3][$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_v[3];
    int   rise_cyc[3];
    int   last_width[3];
    logic [W-1:0] held_sum[3];
    logic         held_cout[3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multicycle_adder #(.WIDTH(W), .CHUNK(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_a(a), .in_b(b), .in_cin(cin),
`ifdef MULTICYCLE_ADDER_SUB_EN
        .in_sub(sub),
`endif
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .out_sum(out_sum_v[0]), .out_cout(out_cout_v[0])
    );

    multicycle_adder #(.WIDTH(W), .CHUNK(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_a(a), .in_b(b), .in_cin(cin),
`ifdef MULTICYCLE_ADDER_SUB_EN
        .in_sub(sub),
`endif
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .out_sum(out_sum_v[1]), .out_cout(out_cout_v[1])
    );

    multicycle_adder #(.WIDTH(W), .CHUNK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .in_a(a), .in_b(b), .in_cin(cin),
`ifdef MULTICYCLE_ADDER_SUB_EN
        .in_sub(sub),
`endif
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .out_sum(out_sum_v[2]), .out_cout(out_cout_v[2])
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Monitor: latency and hold-stability while valid, scoreboard pop on handshake.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                prev_v[k] = 1'b0;
                continue;
            end
            if (out_valid_v[k] && !prev_v[k]) begin
                rise_cyc[k]  = cyc;
                held_sum[k]  = out_sum_v[k];
                held_cout[k] = out_cout_v[k];
                if (sb[k].size() == 0)
                    check($sformatf("unexpected_valid[%0d]", k), 1, 0);
                else
                    check($sformatf("latency[%0d]", k), cyc - sb[k][0].acc, lat_exp[k]);
            end else if (out_valid_v[k] && prev_v[k]) begin
                check($sformatf("held_sum[%0d]", k), out_sum_v[k], held_sum[k]);
                check($sformatf("held_cout[%0d]", k), out_cout_v[k], held_cout[k]);
            end
            if (out_valid_v[k] && out_ready_v[k] && sb[k].size() != 0) begin
                exp_t e;
                e = sb[k].pop_front();
                check($sformatf("sum[%0d]", k), out_sum_v[k], e.sum);
                check($sformatf("cout[%0d]", k), out_cout_v[k], e.cout);
            end
            if (!out_valid_v[k] && prev_v[k])
                last_width[k] = cyc - rise_cyc[k];
            prev_v[k] = out_valid_v[k];
        end
    end

    task automatic issue(input int k, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tc, input logic [W-1:0] es, input logic ec, input logic push);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!in_ready_v[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("in_ready_timeout", 0, 1);
            return;
        end
        a = ta;
        b = tb_v;
        cin = tc;
        in_valid_v[k] = 1'b1;
        if (push) begin
            e.sum = es;
            e.cout = ec;
            e.acc = cyc;
            sb[k].push_back(e);
        end
        @(posedge clk);
        #1 in_valid_v[k] = 1'b0;
`ifdef MULTICYCLE_ADDER_SUB_EN
        sub = 1'b0;
`endif
    endtask

    task automatic wait_done(input int k);
        int n;
        n = 0;
        @(negedge clk);
        while ((sb[k].size() != 0 || out_valid_v[k]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("done_timeout", 0, 1);
        #1;
    endtask

    task automatic wait_valid(input int k);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid_v[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("valid_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
`ifdef MULTICYCLE_ADDER_SUB_EN
        sub = 1'b0;
`endif
        for (int k = 0; k < 3; k++) begin
            in_valid_v[k]  = 1'b0;
            out_ready_v[k] = 1'b1;
            prev_v[k]      = 1'b0;
            last_width[k]  = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_in_ready", in_ready_v[k], 1);
            check("rst_out_valid", out_valid_v[k], 0);
            check("rst_out_sum", out_sum_v[k], 0);
            check("rst_out_cout", out_cout_v[k], 0);
        end
        rst_n = 1'b1;

        issue(0, 16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, 1'b1);
        wait_done(0);
        issue(0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);
        wait_done(0);
        issue(0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1);
        wait_done(0);

        // Backpressure: result held for ten cycles with the consumer stalled.
        out_ready_v[0] = 1'b0;
        issue(0, 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b1);
        wait_valid(0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready_v[0], 0);
            check("bp_out_valid", out_valid_v[0], 1);
            check("bp_out_sum", out_sum_v[0], 16'h1000);
        end
        @(posedge clk);
        #1 out_ready_v[0] = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", out_valid_v[0], 0);
        check("bp_release_ready", in_ready_v[0], 1);
        wait_done(0);

        // Reset two cycles into RUN discards the partial result.
        issue(0, 16'h1111, 16'h2222, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid_v[0], 0);
        check("midrst_out_sum", out_sum_v[0], 0);
        check("midrst_in_ready", in_ready_v[0], 1);
        @(negedge clk);
        rst_n = 1'b1;
        issue(0, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b1);
        wait_done(0);

        // Back-to-back with the consumer always ready.
        issue(0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        issue(0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        check("b2b_width_first", last_width[0], 1);
        wait_done(0);
        check("b2b_width_second", last_width[0], 1);

`ifdef MULTICYCLE_ADDER_SUB_EN
        sub = 1'b1;
        issue(0, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b1);
        wait_done(0);
        sub = 1'b1;
        issue(0, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b1);
        wait_done(0);
`endif

        issue(1, 16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, 1'b1);
        wait_done(1);
        issue(2, 16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, 1'b1);
        wait_done(2);
        issue(2, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);
        wait_done(2);

        for (int k = 0; k < 3; k++)
            check("scoreboard_empty", sb[k].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
